// File: rtl/key_event_encoder.sv
// Debounced key scanner: reports the held priority key and queues press/release
// events in a small show-ahead FIFO with a valid/ready handshake.
module key_event_encoder #(
  parameter int N_KEYS     = 48,
  parameter int CODE_W     = 6,
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LOW_FIRST  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [CODE_W-1:0] held_code,
  output logic              held_valid,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_press
);

  localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [N_KEYS-1:0] s1_q, s2_q;
  logic [N_KEYS-1:0] deb_q, deb_d;
  logic [N_KEYS-1:0] pend_q, pend_d;
  logic [N_KEYS-1:0] flip;
  logic [N_KEYS-1:0] svc_mask;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];

  logic [CODE_W-1:0] held_code_q;
  logic              held_valid_q;

  logic [CODE_W:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;

  logic [CODE_W-1:0] svc_code;
  logic              svc_press;
  logic              full, push, pop;

  // Priority encode; yields N_KEYS when no bit is set.
  function automatic logic [CODE_W-1:0] prio_enc(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = CODE_W'(N_KEYS);
    if (LOW_FIRST != 0) begin
      for (int i = N_KEYS - 1; i >= 0; i--) begin
        if (v[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (v[i]) idx = CODE_W'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    deb_d = deb_q;
    flip  = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
          deb_d[i] = s2_q[i];
          flip[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A bit serviced and flipped on the same edge stays pending for the opposite event.
  always_comb begin
    svc_code  = prio_enc(pend_q);
    full      = (count_q == (AW+1)'(FIFO_DEPTH));
    pop       = (count_q != '0) && evt_ready;
    push      = (|pend_q) && (!full || pop);
    svc_mask  = push ? (N_KEYS'(1) << svc_code) : '0;
    svc_press = |(deb_q & svc_mask);
    pend_d    = (pend_q & ~svc_mask) ^ flip;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + (AW+1)'(1);
    if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      deb_q        <= '0;
      pend_q       <= '0;
      held_code_q  <= CODE_W'(N_KEYS);
      held_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q         <= key;
      s2_q         <= s1_q;
      deb_q        <= deb_d;
      pend_q       <= pend_d;
      held_code_q  <= prio_enc(deb_q);
      held_valid_q <= |deb_q;
      count_q      <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {svc_code, svc_press};
  end

  assign held_code  = held_code_q;
  assign held_valid = held_valid_q;
  assign evt_valid  = (count_q != '0);
  assign evt_code   = evt_valid ? mem_q[rd_ptr_q][CODE_W:1] : '0;
  assign evt_press  = evt_valid ? mem_q[rd_ptr_q][0] : 1'b0;

endmodule
